// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command stream to single APB transfers
// One transfer in flight at a time; wait states bounded by TIMEOUT_CYCLES.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          psel_next, penable_next, pwrite_next;
  logic [31:0]   paddr_next, pwdata_next, rsp_rdata_next;
  logic          rsp_valid_next, rsp_err_next, rsp_timeout_next;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      count       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      psel        <= psel_next;
      penable     <= penable_next;
      pwrite      <= pwrite_next;
      paddr       <= paddr_next;
      pwdata      <= pwdata_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
    end
  end

  always_comb begin
    cmd_ready        = (state == IDLE) && !preset;
    state_next       = state;
    count_next       = count;
    psel_next        = psel;
    penable_next     = penable;
    pwrite_next      = pwrite;
    paddr_next       = paddr;
    pwdata_next      = pwdata;
    rsp_valid_next   = rsp_valid;
    rsp_rdata_next   = rsp_rdata;
    rsp_err_next     = rsp_err;
    rsp_timeout_next = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_next  = cmd_write;
          paddr_next   = cmd_addr;
          pwdata_next  = cmd_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          count_next   = '0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          // pslverr only means anything alongside pready
          rsp_rdata_next   = pwrite ? 32'h0 : prdata;
          rsp_err_next     = pslverr;
          rsp_timeout_next = 1'b0;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = RESP;
        end else if (count == CNT_LAST) begin
          rsp_rdata_next   = 32'h0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = RESP;
        end else begin
          count_next = count + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
